posit_adder_8bit_rr_scheduler: RTL and testbench
================================================

// Module: posit_adder_8bit_rr_scheduler
// PURPOSE
//   Shares one posit_adder_8bit among NREQ requesters using round-robin arbitration.
//   Each requester has a valid/ready operand port. One result port returns each sum
//   tagged with the index of the requester that issued it.
//   Sits between the vector/accumulator clients and the combinational 8-bit posit adder.
//   Two register stages give full throughput: one add per cycle.
// PARAMETERS
//   NREQ   4   number of requesters, 2..16
//   SRCW   2   width of the source tag, = $clog2(NREQ); localparam, not overridable
// PORTS
//   clk        in   1          clock; single clock domain
//   rst        in   1          synchronous, active-high reset
//   req_valid  in   NREQ       requester i presents an operand pair
//   req_ready  out  NREQ       one-hot or zero; operand pair i accepted when valid & ready
//   req_lhs    in   NREQ*8     posit8 lhs, requester i in bits [8i+7:8i]
//   req_rhs    in   NREQ*8     posit8 rhs, same packing
//   res_valid  out  1          result register holds a sum
//   res_ready  in   1          consumer accepts the result when valid & ready
//   res_sum    out  8          posit8 sum of the accepted pair
//   res_src    out  SRCW       index of the requester that issued the pair
//   inflight   out  2          number of ops held in stage A plus stage B (0..2)
// BEHAVIOUR
//   Pipeline
//   - Stage A (operand register): a_vld, a_lhs, a_rhs, a_src.
//   - Stage B (result register): res_valid, res_sum, res_src.
//   - res_sum is registered from posit_adder_8bit(a_lhs, a_rhs).
//   Advance rules
//   - b_take = ~res_valid | res_ready.
//   - a_adv  = a_vld & b_take.
//   - a_take = ~a_vld | a_adv.
//   - req_ready[i] = grant[i] & a_take.
//   - grant is the round-robin pick among req_valid, from combinational sub-module.
//   - req_ready may depend on req_valid; req_valid must not depend on req_ready.
//   Round-robin
//   - Priority pointer ptr; the search starts at ptr and wraps NREQ-1 -> 0.
//   - On an accept by requester g, ptr <= (g+1) mod NREQ. Otherwise ptr holds.
//   - Starvation bound: a requester held valid is accepted within NREQ accepts.
//   Handshake and latency
//   - A pair accepted at edge N gives res_valid=1 after edge N+1 when stage B is free.
//   - With res_ready held at 1, streaming is back-to-back at one result per cycle.
//   - Backpressure (res_ready=0 while res_valid=1): stage B holds. Stage A holds if
//     full. When both are full, all req_ready=0.
//   - res_* stay stable while res_valid=1 and res_ready=0.
//   - No pair is lost or duplicated; per-requester order is preserved.
//   Arithmetic
//   - Special values are not intercepted; the adder resolves them.
//   - 0x80 is NaR: NaR + x gives 0x80.
//   - 0x00 + x gives x.
//   - x + (-x) gives 0x00.
//   inflight
//   - inflight = a_vld + res_valid, updated in the same cycle as the valids.
//   Reset (synchronous)
//   - a_vld=0, res_valid=0, res_sum=0x00, res_src=0, ptr=0, inflight=0.
//   - req_ready is 0 in the cycle rst is high.
//   - Reset mid-operation drops all in-flight ops. No result for them is ever presented.
//   - NREQ=1 is not supported.
// STRUCTURE
//   Shared package posit8_pkg
//   - POSIT8_W=8, POSIT8_NAR=8'h80, POSIT8_ZERO=8'h00.
//   - Function src_width(n) = $clog2(n).
//   Sub-module posit_rr_arbiter #(N)
//   - Inputs: req, ptr. Outputs: one-hot grant, encoded gidx, any.
//   - Purely combinational. Reused by later posit mul/fma schedulers.
//   Top level holds ptr, stages A/B, inflight, and one posit_adder_8bit instance.
// TESTING  (posit8 es=0: 1.0=0x40, 0.5=0x20, 1.5=0x50, 2.0=0x60, -1.0=0xC0)
//   1. Reset, then req0 sends (0x40,0x40) with res_ready=1:
//      - req_ready[0]=1 for one cycle.
//      - Two cycles later res_valid=1, res_sum=0x60, res_src=0.
//   2. All 4 requesters held valid with pairs, res_ready=1:
//      - Grants come in order 0,1,2,3,0,...
//      - One result per cycle; res_src follows the same order.
//   3. req1 sends (0x40,0x20), then res_ready=0 for 5 cycles:
//      - res_sum=0x50 held stable; inflight reaches 2.
//      - All req_ready=0 once stage A is full.
//      - On release the results drain in order with no loss.
//   4. Special values:
//      - (0x80,0x40) gives 0x80.
//      - (0x40,0xC0) gives 0x00.
//      - (0x00,0x20) gives 0x20.
//   5. Assert rst while inflight=2 and all req_valid=1:
//      - Next cycle res_valid=0, inflight=0, ptr=0.
//      - The first post-reset grant goes to req0.
//   6. Only req2 valid, then req0 and req2 valid together:
//      - After req2 is accepted, ptr=3.
//      - The next grant goes to req0; the one after goes to req2.

Source files
------------

// File: rtl/posit8_pkg.sv
// Shared posit8 (es=0) constants, payload types and helpers for the posit schedulers.
package posit8_pkg;

   localparam int unsigned POSIT8_W    = 8;
   localparam logic [7:0]  POSIT8_NAR  = 8'h80;
   localparam logic [7:0]  POSIT8_ZERO = 8'h00;

   // Every posit8 es=0 value is an exact multiple of 2^-6; sums fit in 15 signed bits.
   localparam int unsigned P8_FIX_W = 15;

   typedef struct packed {
      logic [POSIT8_W-1:0] lhs;
      logic [POSIT8_W-1:0] rhs;
   } posit8_pair_t;

   function automatic int unsigned src_width(input int unsigned n);
      return $clog2(n);
   endfunction

endpackage

// File: rtl/posit_adder_8bit.sv
// Combinational posit8 (es=0) adder: exact fixed-point sum, then round-to-nearest-even re-encode.
module posit_adder_8bit
   import posit8_pkg::*;
(
   input  logic [POSIT8_W-1:0] a_i,
   input  logic [POSIT8_W-1:0] b_i,
   output logic [POSIT8_W-1:0] sum_o
);

   function automatic logic signed [P8_FIX_W-1:0] p8_decode(input logic [7:0] p);
      logic [7:0]  m;
      logic        r0;
      logic [3:0]  run;
      logic        done;
      logic [3:0]  nf;
      logic [3:0]  sh;
      logic [6:0]  frac;
      logic [12:0] mant;
      logic [12:0] mag;
      m    = p[7] ? (8'd0 - p) : p;
      r0   = m[6];
      run  = 4'd1;
      done = 1'b0;
      for (int i = 5; i >= 0; i--) begin
         if (!done && (m[i] == r0)) run = run + 4'd1;
         else done = 1'b1;
      end
      nf   = (run >= 4'd6) ? 4'd0 : (4'd6 - run);
      frac = m[6:0] & ((7'd1 << nf) - 7'd1);
      sh   = 4'd0;
      if (r0) sh = (run == 4'd7) ? 4'd12 : ((run << 1) - 4'd1);
      mant = (13'd1 << nf) | 13'(frac);
      mag  = mant << sh;
      if (p == POSIT8_ZERO) mag = 13'd0;
      return p[7] ? -P8_FIX_W'(mag) : P8_FIX_W'(mag);
   endfunction

   function automatic logic [7:0] p8_encode(input logic signed [P8_FIX_W-1:0] s);
      logic [13:0] mg;
      logic [26:0] rg;
      logic [26:0] x;
      logic [6:0]  res;
      logic        g;
      logic        st;
      int          h;
      int          k;
      int          l;
      mg  = s[14] ? 14'(-s) : s[13:0];
      h   = 0;
      for (int i = 0; i < 14; i++) begin
         if (mg[i]) h = i;
      end
      k   = h - 6;
      res = 7'h7F;
      if (k < 6) begin
         if (k >= 0) begin
            l  = k + 2;
            rg = 27'(((1 << (k + 1)) - 1) << 1);
         end else begin
            l  = 1 - k;
            rg = 27'd1;
         end
         x   = (rg << (27 - l)) | ((27'(mg) & ((27'd1 << h) - 27'd1)) << (27 - l - h));
         res = x[26:20];
         g   = x[19];
         st  = |x[18:0];
         if (g && (st || res[0])) res = res + 7'd1;
      end
      if (s == '0) return POSIT8_ZERO;
      return s[14] ? (8'd0 - {1'b0, res}) : {1'b0, res};
   endfunction

   logic signed [P8_FIX_W-1:0] fix_sum;

   always_comb begin
      fix_sum = p8_decode(a_i) + p8_decode(b_i);
      sum_o   = p8_encode(fix_sum);
      if ((a_i == POSIT8_NAR) || (b_i == POSIT8_NAR)) sum_o = POSIT8_NAR;
   end

endmodule

// File: rtl/posit_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping N-1 -> 0.
module posit_rr_arbiter #(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = posit8_pkg::src_width(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] gidx_o,
   output logic          any_o
);

   localparam int unsigned SW = IW + 1;

   logic [SW-1:0] pos;
   logic [IW-1:0] idx;
   logic          found;

   always_comb begin
      grant_o = '0;
      gidx_o  = '0;
      any_o   = 1'b0;
      found   = 1'b0;
      pos     = '0;
      idx     = '0;
      for (int j = 0; j < N; j++) begin
         pos = {1'b0, ptr_i} + SW'(j);
         if (pos >= SW'(N)) pos = pos - SW'(N);
         idx = pos[IW-1:0];
         if (!found && req_i[idx]) begin
            found        = 1'b1;
            grant_o[idx] = 1'b1;
            gidx_o       = idx;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/posit_adder_8bit_rr_scheduler.sv
// Round-robin sharing of one posit8 adder among NREQ requesters; operand and result register stages.
module posit_adder_8bit_rr_scheduler
   import posit8_pkg::*;
#(
   parameter  int unsigned NREQ = 4,
   localparam int unsigned SRCW = src_width(NREQ)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*POSIT8_W-1:0] req_lhs,
   input  logic [NREQ*POSIT8_W-1:0] req_rhs,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [POSIT8_W-1:0]      res_sum,
   output logic [SRCW-1:0]          res_src,
   output logic [1:0]               inflight
);

   logic [SRCW-1:0]     ptr_q, ptr_d;
   logic                a_vld_q, a_vld_d;
   posit8_pair_t        a_pair_q, a_pair_d;
   logic [SRCW-1:0]     a_src_q, a_src_d;
   logic                res_valid_q, res_valid_d;
   logic [POSIT8_W-1:0] res_sum_q, res_sum_d;
   logic [SRCW-1:0]     res_src_q, res_src_d;
   logic [1:0]          inflight_q, inflight_d;

   logic [NREQ-1:0]     gnt;
   logic [SRCW-1:0]     gidx;
   logic                gnt_any;
   logic [POSIT8_W-1:0] add_sum;
   logic [POSIT8_W-1:0] lhs_arr [NREQ];
   logic [POSIT8_W-1:0] rhs_arr [NREQ];
   logic                b_take;
   logic                a_adv;
   logic                a_take;
   logic                accept;

   posit_rr_arbiter #(.N(NREQ)) u_arb (
      .req_i   (req_valid),
      .ptr_i   (ptr_q),
      .grant_o (gnt),
      .gidx_o  (gidx),
      .any_o   (gnt_any)
   );

   posit_adder_8bit u_add (
      .a_i   (a_pair_q.lhs),
      .b_i   (a_pair_q.rhs),
      .sum_o (add_sum)
   );

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         lhs_arr[i] = req_lhs[i*POSIT8_W +: POSIT8_W];
         rhs_arr[i] = req_rhs[i*POSIT8_W +: POSIT8_W];
      end
   end

   // Handshake and next-state for both pipeline stages and the priority pointer.
   always_comb begin
      ptr_d       = ptr_q;
      a_vld_d     = a_vld_q;
      a_pair_d    = a_pair_q;
      a_src_d     = a_src_q;
      res_valid_d = res_valid_q;
      res_sum_d   = res_sum_q;
      res_src_d   = res_src_q;

      b_take    = ~res_valid_q | res_ready;
      a_adv     = a_vld_q & b_take;
      a_take    = ~a_vld_q | a_adv;
      accept    = gnt_any & a_take & ~rst;
      req_ready = rst ? '0 : (gnt & {NREQ{a_take}});

      if (a_adv) begin
         res_valid_d = 1'b1;
         res_sum_d   = add_sum;
         res_src_d   = a_src_q;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end

      if (accept) begin
         a_vld_d      = 1'b1;
         a_pair_d.lhs = lhs_arr[gidx];
         a_pair_d.rhs = rhs_arr[gidx];
         a_src_d      = gidx;
         ptr_d        = (gidx == SRCW'(NREQ - 1)) ? '0 : (gidx + SRCW'(1));
      end else if (a_adv) begin
         a_vld_d = 1'b0;
      end

      inflight_d = {1'b0, a_vld_d} + {1'b0, res_valid_d};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q       <= '0;
         a_vld_q     <= 1'b0;
         a_pair_q    <= '0;
         a_src_q     <= '0;
         res_valid_q <= 1'b0;
         res_sum_q   <= POSIT8_ZERO;
         res_src_q   <= '0;
         inflight_q  <= 2'd0;
      end else begin
         ptr_q       <= ptr_d;
         a_vld_q     <= a_vld_d;
         a_pair_q    <= a_pair_d;
         a_src_q     <= a_src_d;
         res_valid_q <= res_valid_d;
         res_sum_q   <= res_sum_d;
         res_src_q   <= res_src_d;
         inflight_q  <= inflight_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_sum   = res_sum_q;
   assign res_src   = res_src_q;
   assign inflight  = inflight_q;

endmodule

// File: tb/tb_posit_adder_8bit_rr_scheduler.sv
// Scoreboard bench for the round-robin posit8 adder scheduler using hand-computed posit sums.
module tb_posit_adder_8bit_rr_scheduler;

   localparam int unsigned NREQ = 4;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*8-1:0] req_lhs;
   logic [NREQ*8-1:0] req_rhs;
   logic              res_valid;
   logic              res_ready;
   logic [7:0]        res_sum;
   logic [1:0]        res_src;
   logic [1:0]        inflight;

   int checks;
   int failures;
   int results_seen;

   logic [7:0] pl [NREQ][16];
   logic [7:0] pr [NREQ][16];
   int         hd [NREQ];
   int         tl [NREQ];
   logic [9:0] exp_q [$];

   posit_adder_8bit_rr_scheduler #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lhs   (req_lhs),
      .req_rhs   (req_rhs),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_sum   (res_sum),
      .res_src   (res_src),
      .inflight  (inflight)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1);
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue(input int r, input logic [7:0] l, input logic [7:0] rh, input logic [7:0] s);
      pl[r][tl[r] % 16] = l;
      pr[r][tl[r] % 16] = rh;
      tl[r]++;
      exp_q.push_back({2'(r), s});
   endtask

   // Present queued pairs, record which were accepted, then advance one clock.
   task automatic step(output logic [3:0] acc);
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]       = (hd[i] != tl[i]);
         req_lhs[8*i +: 8]  = pl[i][hd[i] % 16];
         req_rhs[8*i +: 8]  = pr[i][hd[i] % 16];
      end
      #2;
      acc = req_valid & req_ready;
      for (int i = 0; i < NREQ; i++) begin
         if (acc[i]) hd[i]++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      for (int i = 0; i < NREQ; i++) begin
         hd[i] = 0;
         tl[i] = 0;
      end
      exp_q.delete();
      req_valid = '0;
   endtask

   task automatic do_reset(input string tag);
      rst       = 1'b1;
      req_valid = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush();
      chk({tag, "_res_valid"}, int'(res_valid), 0);
      chk({tag, "_res_sum"},   int'(res_sum),   0);
      chk({tag, "_res_src"},   int'(res_src),   0);
      chk({tag, "_inflight"},  int'(inflight),  0);
   endtask

   task automatic drain(input string tag);
      logic [3:0] a;
      int n;
      n = 0;
      while ((exp_q.size() != 0) && (n < 60)) begin
         step(a);
         n++;
      end
      chk({tag, "_all_results_returned"}, exp_q.size(), 0);
   endtask

   task automatic monitor();
      logic [9:0] e;
      forever begin
         @(negedge clk);
         if (!rst && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
               chk("spurious_res_valid", int'(res_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("res_sum", int'(res_sum), int'(e[7:0]));
               chk("res_src", int'(res_src), int'(e[9:8]));
               results_seen++;
            end
         end
      end
   endtask

   initial begin
      logic [3:0] a;
      int base;
      checks       = 0;
      failures     = 0;
      results_seen = 0;
      rst          = 1'b1;
      res_ready    = 1'b0;
      req_valid    = '0;
      req_lhs      = '0;
      req_rhs      = '0;
      flush();
      fork
         monitor();
      join_none
      @(posedge clk);
      #1;

      // 1: single add, 1.0 + 1.0 = 2.0, latency
      do_reset("s1_rst");
      res_ready = 1'b1;
      issue(0, 8'h40, 8'h40, 8'h60);
      step(a);
      chk("s1_ready_once", int'(a), 1);
      chk("s1_res_not_yet", int'(res_valid), 0);
      chk("s1_inflight_a", int'(inflight), 1);
      step(a);
      chk("s1_no_second_accept", int'(a), 0);
      chk("s1_res_valid", int'(res_valid), 1);
      chk("s1_inflight_b", int'(inflight), 1);
      step(a);
      chk("s1_inflight_empty", int'(inflight), 0);

      // 2: all requesters busy, grants rotate 0,1,2,3,0,...
      do_reset("s2_rst");
      res_ready = 1'b1;
      base = results_seen;
      issue(0, 8'h40, 8'h40, 8'h60);
      issue(1, 8'h40, 8'h20, 8'h50);
      issue(2, 8'h20, 8'h20, 8'h40);
      issue(3, 8'h40, 8'hC0, 8'h00);
      issue(0, 8'h50, 8'h40, 8'h64);
      issue(1, 8'h60, 8'h60, 8'h70);
      issue(2, 8'hC0, 8'hC0, 8'hA0);
      issue(3, 8'h00, 8'h20, 8'h20);
      for (int k = 0; k < 8; k++) begin
         step(a);
         chk($sformatf("s2_grant%0d", k), int'(a), 1 << (k % 4));
      end
      step(a);
      step(a);
      chk("s2_result_count", results_seen - base, 8);
      drain("s2");

      // 3: backpressure, stage A and B both fill, then drain
      do_reset("s3_rst");
      res_ready = 1'b0;
      issue(1, 8'h40, 8'h20, 8'h50);
      issue(1, 8'h40, 8'h40, 8'h60);
      issue(1, 8'h20, 8'h20, 8'h40);
      step(a);
      chk("s3_accept0", int'(a), 2);
      step(a);
      chk("s3_accept1", int'(a), 2);
      chk("s3_inflight_full", int'(inflight), 2);
      for (int c = 0; c < 3; c++) begin
         step(a);
         chk($sformatf("s3_stall_ready%0d", c), int'(a), 0);
         chk($sformatf("s3_hold_valid%0d", c), int'(res_valid), 1);
         chk($sformatf("s3_hold_sum%0d", c), int'(res_sum), 8'h50);
         chk($sformatf("s3_hold_src%0d", c), int'(res_src), 1);
         chk($sformatf("s3_hold_inflight%0d", c), int'(inflight), 2);
      end
      res_ready = 1'b1;
      drain("s3");

      // 4: special values and rounding ties
      do_reset("s4_rst");
      res_ready = 1'b1;
      issue(0, 8'h80, 8'h40, 8'h80);
      issue(1, 8'h40, 8'hC0, 8'h00);
      issue(2, 8'h00, 8'h20, 8'h20);
      issue(3, 8'h40, 8'h03, 8'h42);
      issue(0, 8'h40, 8'h01, 8'h40);
      drain("s4");

      // 5: reset while full drops everything; first grant afterwards is req0
      do_reset("s5_rst");
      res_ready = 1'b0;
      for (int r = 0; r < NREQ; r++) begin
         issue(r, 8'h40, 8'h40, 8'h60);
         issue(r, 8'h40, 8'h40, 8'h60);
      end
      step(a);
      step(a);
      chk("s5_inflight_full", int'(inflight), 2);
      rst = 1'b1;
      #2;
      chk("s5_ready_during_rst", int'(req_ready), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush();
      chk("s5_res_valid_dropped", int'(res_valid), 0);
      chk("s5_inflight_dropped", int'(inflight), 0);
      for (int r = 0; r < NREQ; r++) issue(r, 8'h20, 8'h20, 8'h40);
      res_ready = 1'b1;
      step(a);
      chk("s5_first_grant", int'(a), 1);
      drain("s5");

      // 6: pointer advances past the accepted requester
      do_reset("s6_rst");
      res_ready = 1'b1;
      issue(2, 8'h40, 8'h40, 8'h60);
      step(a);
      chk("s6_only_req2", int'(a), 4);
      issue(0, 8'h20, 8'h40, 8'h50);
      issue(2, 8'h50, 8'h50, 8'h68);
      step(a);
      chk("s6_grant_req0", int'(a), 1);
      step(a);
      chk("s6_grant_req2", int'(a), 4);
      drain("s6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
